// File: rtl/ram_sized_pkg.sv
// Shared constants and types for the sized data RAM and its lane aligner.
package ram_sized_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 10;
  localparam int DEFAULT_DATA_WIDTH = 32;

  localparam logic [1:0] RAM_SIZE_BYTE  = 2'd0;
  localparam logic [1:0] RAM_SIZE_HALF  = 2'd1;
  localparam logic [1:0] RAM_SIZE_WORD  = 2'd2;
  localparam logic [1:0] RAM_SIZE_DWORD = 2'd3;

  localparam logic RAM_READ  = 1'b0;
  localparam logic RAM_WRITE = 1'b1;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_t;

endpackage

// File: rtl/ram_lane_align.sv
// Byte-lane steering for sized accesses: store merge, load extraction/extension,
// and alignment checking. Purely combinational.
module ram_lane_align
  import ram_sized_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  localparam int NB = DATA_WIDTH / 8,
  localparam int OFFS = $clog2(NB)
) (
  input  logic [OFFS-1:0]       offset,
  input  logic [1:0]            size,
  input  logic                  is_signed,
  input  logic [DATA_WIDTH-1:0] raw,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [NB-1:0]         byte_en,
  output logic [DATA_WIDTH-1:0] merged,
  output logic [DATA_WIDTH-1:0] load_val,
  output logic                  misalign
);

  logic [DATA_WIDTH-1:0] shifted_w;
  logic [DATA_WIDTH-1:0] shifted_r;
  logic                  sign_bit;
  int                    size_bytes;
  int                    nbits;
  int                    off_int;

  // Decode size/offset, then steer store bytes into lanes and load bytes down to bit 0.
  always_comb begin
    size_bytes = 1 << size;
    nbits      = 8 * size_bytes;
    if (nbits > DATA_WIDTH) nbits = DATA_WIDTH;
    off_int    = int'(offset);

    misalign = DISABLE;
    case (size)
      RAM_SIZE_HALF:  misalign = offset[0];
      RAM_SIZE_WORD:  misalign = (offset[1:0] != 2'b00);
      RAM_SIZE_DWORD: misalign = (DATA_WIDTH == 32) || (offset != '0);
      default:        misalign = DISABLE;
    endcase

    shifted_w = wdata << (8 * off_int);
    shifted_r = raw >> (8 * off_int);

    byte_en = '0;
    merged  = raw;
    for (int i = 0; i < NB; i++) begin
      byte_en[i] = !misalign && (i >= off_int) && (i < off_int + size_bytes);
      if (byte_en[i]) merged[8*i +: 8] = shifted_w[8*i +: 8];
    end

    sign_bit = 1'b0;
    for (int b = 0; b < DATA_WIDTH; b++) begin
      if (b == nbits - 1) sign_bit = is_signed & shifted_r[b];
    end

    load_val = '0;
    for (int b = 0; b < DATA_WIDTH; b++) begin
      load_val[b] = (b < nbits) ? shifted_r[b] : sign_bit;
    end
  end

endmodule

// File: rtl/ram_sized.sv
// Single-port sized data RAM with valid/ready requests, one-cycle responses
// and a hardware clear sweep that zeroes the array one word per cycle.
module ram_sized
  import ram_sized_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wr,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  input  logic                  clr_start,
  output logic                  clr_busy
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int OFFS  = $clog2(NB);
  localparam int IDX_W = ADDR_WIDTH - OFFS;
  localparam int DEPTH = 2 ** IDX_W;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  clr_state_t            state;
  logic [IDX_W-1:0]      clr_cnt;

  logic [IDX_W-1:0]      word_idx;
  logic [OFFS-1:0]       offset;
  logic [DATA_WIDTH-1:0] raw;
  logic [NB-1:0]         byte_en;
  logic [DATA_WIDTH-1:0] merged;
  logic [DATA_WIDTH-1:0] load_val;
  logic                  misalign;
  logic                  accept;

  assign word_idx  = req_addr[ADDR_WIDTH-1:OFFS];
  assign offset    = req_addr[OFFS-1:0];
  assign raw       = mem[word_idx];
  assign req_ready = (state == IDLE) && !clr_start;
  assign accept    = req_valid && req_ready;
  assign clr_busy  = (state == CLEAR);

  ram_lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .offset    (offset),
    .size      (req_size),
    .is_signed (req_signed),
    .raw       (raw),
    .wdata     (req_wdata),
    .byte_en   (byte_en),
    .merged    (merged),
    .load_val  (load_val),
    .misalign  (misalign)
  );

  // Clear sequencer: IDLE serves requests, CLEAR walks every word once then returns.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      clr_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (clr_start) begin
            state   <= CLEAR;
            clr_cnt <= '0;
          end
        end
        CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (&clr_cnt) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // One-cycle response for every accepted request; data only for good loads.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      resp_valid <= accept;
      resp_err   <= accept && misalign;
      resp_rdata <= (accept && (req_wr == RAM_READ) && !misalign) ? load_val : '0;
    end
  end

  // Array write port, shared between the clear sweep and aligned stores; never reset.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[clr_cnt] <= '0;
    end else if (accept && (req_wr == RAM_WRITE) && !misalign && (byte_en != '0)) begin
      mem[word_idx] <= merged;
    end
  end

endmodule

// File: tb/tb_ram_sized.sv
// Directed self-checking bench for ram_sized: a 32-bit instance for the main
// scenarios and a 64-bit instance for dword accesses.
module tb_ram_sized;

  logic clk = 1'b0;
  logic reset = 1'b0;

  logic        a_req_valid = 1'b0, a_req_ready, a_req_wr = 1'b0, a_req_signed = 1'b0;
  logic [1:0]  a_req_size = 2'd0;
  logic [9:0]  a_req_addr = '0;
  logic [31:0] a_req_wdata = '0, a_resp_rdata;
  logic        a_resp_valid, a_resp_err, a_clr_start = 1'b0, a_clr_busy;

  logic        b_req_valid = 1'b0, b_req_ready, b_req_wr = 1'b0, b_req_signed = 1'b0;
  logic [1:0]  b_req_size = 2'd0;
  logic [9:0]  b_req_addr = '0;
  logic [63:0] b_req_wdata = '0, b_resp_rdata;
  logic        b_resp_valid, b_resp_err, b_clr_start = 1'b0, b_clr_busy;

  int checks = 0;
  int errors = 0;

  ram_sized #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) dut_a (
    .clk(clk), .reset(reset),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_wr(a_req_wr),
    .req_size(a_req_size), .req_signed(a_req_signed), .req_addr(a_req_addr),
    .req_wdata(a_req_wdata), .resp_valid(a_resp_valid), .resp_rdata(a_resp_rdata),
    .resp_err(a_resp_err), .clr_start(a_clr_start), .clr_busy(a_clr_busy)
  );

  ram_sized #(.ADDR_WIDTH(10), .DATA_WIDTH(64)) dut_b (
    .clk(clk), .reset(reset),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_wr(b_req_wr),
    .req_size(b_req_size), .req_signed(b_req_signed), .req_addr(b_req_addr),
    .req_wdata(b_req_wdata), .resp_valid(b_resp_valid), .resp_rdata(b_resp_rdata),
    .resp_err(b_resp_err), .clr_start(b_clr_start), .clr_busy(b_clr_busy)
  );

  always #5 clk = ~clk;

  // Present one request to the 32-bit instance at a negedge; returns one negedge later with the response visible.
  task automatic issue_a(input logic wr, input logic [1:0] size, input logic sgn,
                         input logic [9:0] addr, input logic [31:0] wdata);
    a_req_valid = 1'b1; a_req_wr = wr; a_req_size = size; a_req_signed = sgn;
    a_req_addr = addr; a_req_wdata = wdata;
    @(negedge clk);
    a_req_valid = 1'b0;
  endtask

  // Same as issue_a for the 64-bit instance.
  task automatic issue_b(input logic wr, input logic [1:0] size, input logic sgn,
                         input logic [9:0] addr, input logic [63:0] wdata);
    b_req_valid = 1'b1; b_req_wr = wr; b_req_size = size; b_req_signed = sgn;
    b_req_addr = addr; b_req_wdata = wdata;
    @(negedge clk);
    b_req_valid = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (a_resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_resp_valid: got %b expected 0", a_resp_valid); end
    checks++; if (a_resp_rdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_resp_rdata: got %h expected 0", a_resp_rdata); end
    checks++; if (a_resp_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_resp_err: got %b expected 0", a_resp_err); end
    checks++; if (a_clr_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_clr_busy: got %b expected 0", a_clr_busy); end
    checks++; if (a_req_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_req_ready: got %b expected 1", a_req_ready); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_store_load();
    issue_a(1'b1, 2'd2, 1'b0, 10'h008, 32'h8000_003F);
    checks++; if (a_resp_valid !== 1'b1 || a_resp_err !== 1'b0 || a_resp_rdata !== 32'h0) begin errors++;
      $display("[TB] FAIL store_word_resp: got v=%b e=%b d=%h expected v=1 e=0 d=00000000", a_resp_valid, a_resp_err, a_resp_rdata); end
    issue_a(1'b0, 2'd2, 1'b1, 10'h008, 32'h0);
    checks++; if (a_resp_valid !== 1'b1 || a_resp_err !== 1'b0 || a_resp_rdata !== 32'h8000_003F) begin errors++;
      $display("[TB] FAIL load_word_raw: got v=%b e=%b d=%h expected v=1 e=0 d=8000003f", a_resp_valid, a_resp_err, a_resp_rdata); end
    @(negedge clk);
    checks++; if (a_resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL idle_resp_valid: got %b expected 0", a_resp_valid); end
  endtask

  task automatic test_back_to_back();
    issue_a(1'b1, 2'd0, 1'b0, 10'h009, 32'h0000_00AB);
    checks++; if (a_resp_valid !== 1'b1 || a_resp_err !== 1'b0) begin errors++;
      $display("[TB] FAIL store_byte_resp: got v=%b e=%b expected v=1 e=0", a_resp_valid, a_resp_err); end
    issue_a(1'b0, 2'd0, 1'b0, 10'h009, 32'h0);
    checks++; if (a_resp_valid !== 1'b1 || a_resp_rdata !== 32'h0000_00AB) begin errors++;
      $display("[TB] FAIL load_byte_unsigned: got v=%b d=%h expected v=1 d=000000ab", a_resp_valid, a_resp_rdata); end
    issue_a(1'b0, 2'd0, 1'b1, 10'h009, 32'h0);
    checks++; if (a_resp_valid !== 1'b1 || a_resp_rdata !== 32'hFFFF_FFAB) begin errors++;
      $display("[TB] FAIL load_byte_signed: got v=%b d=%h expected v=1 d=ffffffab", a_resp_valid, a_resp_rdata); end
    issue_a(1'b0, 2'd2, 1'b0, 10'h008, 32'h0);
    checks++; if (a_resp_valid !== 1'b1 || a_resp_rdata !== 32'h8000_AB3F) begin errors++;
      $display("[TB] FAIL load_word_merged: got v=%b d=%h expected v=1 d=8000ab3f", a_resp_valid, a_resp_rdata); end
    issue_a(1'b0, 2'd1, 1'b1, 10'h00A, 32'h0);
    checks++; if (a_resp_rdata !== 32'hFFFF_8000 || a_resp_err !== 1'b0) begin errors++;
      $display("[TB] FAIL load_half_signed_hi: got e=%b d=%h expected e=0 d=ffff8000", a_resp_err, a_resp_rdata); end
    issue_a(1'b0, 2'd1, 1'b0, 10'h008, 32'h0);
    checks++; if (a_resp_rdata !== 32'h0000_AB3F) begin errors++;
      $display("[TB] FAIL load_half_unsigned_lo: got %h expected 0000ab3f", a_resp_rdata); end
  endtask

  task automatic test_misalign();
    issue_a(1'b1, 2'd1, 1'b0, 10'h00B, 32'h0000_1234);
    checks++; if (a_resp_valid !== 1'b1 || a_resp_err !== 1'b1 || a_resp_rdata !== 32'h0) begin errors++;
      $display("[TB] FAIL misaligned_half_store: got v=%b e=%b d=%h expected v=1 e=1 d=00000000", a_resp_valid, a_resp_err, a_resp_rdata); end
    issue_a(1'b0, 2'd2, 1'b0, 10'h00A, 32'h0);
    checks++; if (a_resp_err !== 1'b1 || a_resp_rdata !== 32'h0) begin errors++;
      $display("[TB] FAIL misaligned_word_load: got e=%b d=%h expected e=1 d=00000000", a_resp_err, a_resp_rdata); end
    issue_a(1'b0, 2'd3, 1'b0, 10'h008, 32'h0);
    checks++; if (a_resp_err !== 1'b1 || a_resp_rdata !== 32'h0) begin errors++;
      $display("[TB] FAIL dword_on_32bit: got e=%b d=%h expected e=1 d=00000000", a_resp_err, a_resp_rdata); end
    issue_a(1'b0, 2'd2, 1'b0, 10'h008, 32'h0);
    checks++; if (a_resp_err !== 1'b0 || a_resp_rdata !== 32'h8000_AB3F) begin errors++;
      $display("[TB] FAIL word_unchanged_after_err: got e=%b d=%h expected e=0 d=8000ab3f", a_resp_err, a_resp_rdata); end
  endtask

  task automatic test_clear();
    int busy_cycles;
    issue_a(1'b1, 2'd2, 1'b0, 10'h3FC, 32'hDEAD_BEEF);
    a_clr_start = 1'b1;
    a_req_valid = 1'b1; a_req_wr = 1'b1; a_req_size = 2'd2; a_req_addr = 10'h004; a_req_wdata = 32'h1111_1111;
    #1;
    checks++; if (a_req_ready !== 1'b0) begin errors++; $display("[TB] FAIL clear_blocks_ready: got %b expected 0", a_req_ready); end
    @(negedge clk);
    a_clr_start = 1'b0; a_req_valid = 1'b0;
    checks++; if (a_resp_valid !== 1'b0 || a_clr_busy !== 1'b1) begin errors++;
      $display("[TB] FAIL clear_start_state: got v=%b busy=%b expected v=0 busy=1", a_resp_valid, a_clr_busy); end
    busy_cycles = a_clr_busy ? 1 : 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (a_clr_busy) busy_cycles++;
      else break;
    end
    checks++; if (busy_cycles != 256) begin errors++; $display("[TB] FAIL clear_busy_length: got %0d expected 256", busy_cycles); end
    issue_a(1'b0, 2'd2, 1'b0, 10'h008, 32'h0);
    checks++; if (a_resp_valid !== 1'b1 || a_resp_rdata !== 32'h0) begin errors++;
      $display("[TB] FAIL cleared_word_008: got v=%b d=%h expected v=1 d=00000000", a_resp_valid, a_resp_rdata); end
    issue_a(1'b0, 2'd2, 1'b0, 10'h3FC, 32'h0);
    checks++; if (a_resp_valid !== 1'b1 || a_resp_rdata !== 32'h0) begin errors++;
      $display("[TB] FAIL cleared_word_3fc: got v=%b d=%h expected v=1 d=00000000", a_resp_valid, a_resp_rdata); end
  endtask

  task automatic test_reset_during_clear();
    issue_a(1'b1, 2'd2, 1'b0, 10'h100, 32'h1234_5678);
    issue_a(1'b1, 2'd2, 1'b0, 10'h000, 32'hCAFE_F00D);
    a_clr_start = 1'b1;
    @(negedge clk);
    a_clr_start = 1'b0;
    repeat (10) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checks++; if (a_clr_busy !== 1'b0 || a_resp_valid !== 1'b0) begin errors++;
      $display("[TB] FAIL abort_clear: got busy=%b v=%b expected busy=0 v=0", a_clr_busy, a_resp_valid); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    issue_a(1'b0, 2'd2, 1'b0, 10'h000, 32'h0);
    checks++; if (a_resp_valid !== 1'b1 || a_resp_rdata !== 32'h0) begin errors++;
      $display("[TB] FAIL swept_word0: got v=%b d=%h expected v=1 d=00000000", a_resp_valid, a_resp_rdata); end
    issue_a(1'b0, 2'd2, 1'b0, 10'h100, 32'h0);
    checks++; if (a_resp_rdata !== 32'h1234_5678) begin errors++;
      $display("[TB] FAIL unswept_word64: got %h expected 12345678", a_resp_rdata); end
  endtask

  task automatic test_dword();
    issue_b(1'b1, 2'd3, 1'b0, 10'h010, 64'h0123_4567_89AB_CDEF);
    checks++; if (b_resp_valid !== 1'b1 || b_resp_err !== 1'b0) begin errors++;
      $display("[TB] FAIL dword_store_resp: got v=%b e=%b expected v=1 e=0", b_resp_valid, b_resp_err); end
    issue_b(1'b0, 2'd1, 1'b1, 10'h016, 64'h0);
    checks++; if (b_resp_rdata !== 64'h0000_0000_0000_0123 || b_resp_err !== 1'b0) begin errors++;
      $display("[TB] FAIL half_signed_016: got e=%b d=%h expected e=0 d=0000000000000123", b_resp_err, b_resp_rdata); end
    issue_b(1'b0, 2'd3, 1'b0, 10'h014, 64'h0);
    checks++; if (b_resp_err !== 1'b1 || b_resp_rdata !== 64'h0) begin errors++;
      $display("[TB] FAIL dword_misaligned_014: got e=%b d=%h expected e=1 d=0", b_resp_err, b_resp_rdata); end
    issue_b(1'b0, 2'd0, 1'b1, 10'h011, 64'h0);
    checks++; if (b_resp_rdata !== 64'hFFFF_FFFF_FFFF_FFCD) begin errors++;
      $display("[TB] FAIL byte_signed_011: got %h expected ffffffffffffffcd", b_resp_rdata); end
    issue_b(1'b0, 2'd2, 1'b0, 10'h014, 64'h0);
    checks++; if (b_resp_rdata !== 64'h0000_0000_0123_4567) begin errors++;
      $display("[TB] FAIL word_unsigned_014: got %h expected 0000000001234567", b_resp_rdata); end
    issue_b(1'b0, 2'd3, 1'b0, 10'h010, 64'h0);
    checks++; if (b_resp_rdata !== 64'h0123_4567_89AB_CDEF || b_resp_err !== 1'b0) begin errors++;
      $display("[TB] FAIL dword_load_010: got e=%b d=%h expected e=0 d=0123456789abcdef", b_resp_err, b_resp_rdata); end
  endtask

  // Sequence the scenarios and print the summary.
  initial begin
    test_reset();
    test_dword();
    test_store_load();
    test_back_to_back();
    test_misalign();
    test_clear();
    test_reset_during_clear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog so a stuck run still terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
